rr_arb_mux: RTL
===============

// Module: rr_arb_mux
// PURPOSE
//   Registered N:1 arbitrating mux with valid/ready handshake on every input and on the output.
//   Generalises the 2:1 combinational mux to NUM_IN channels with one output register stage.
//   Selection is fixed-priority or round-robin.
//   Sits between multiple producers (e.g. writeback sources, memory request queues) and one shared consumer.
// PARAMETERS
//   SIZE    31  MSB index of each data word; word width = SIZE+1
//   NUM_IN  4   number of input channels, >= 2
//   MODE    1   0 = fixed priority (lowest index wins), 1 = round-robin
//   SEL_W   $clog2(NUM_IN)  width of out_sel; localparam, not overridable
// PORTS
//   clk        in   1                   rising-edge clock
//   rst_n      in   1                   synchronous reset, active-low
//   in_valid   in   NUM_IN              per-channel request
//   in_data    in   NUM_IN*(SIZE+1)     channel i occupies bits [i*(SIZE+1) +: SIZE+1]
//   in_ready   out  NUM_IN              per-channel accept; one-hot or zero
//   out_valid  out  1                   output register holds a word
//   out_data   out  SIZE+1              registered selected word
//   out_sel    out  SEL_W               index of the channel that supplied out_data
//   out_ready  in   1                   consumer accepts the output word
// BEHAVIOUR
//   Reset (rst_n=0 at posedge)
//     - out_valid=0, out_data=0, out_sel=0, rr pointer=0.
//     - in_ready=0 while rst_n=0.
//   Capacity
//     - One output register; load_en = ~out_valid | out_ready (combinational).
//   Grant (combinational from in_valid and pointer)
//     - MODE=0: grant the lowest index i with in_valid[i]=1.
//     - MODE=1: search from ptr upward, wrapping NUM_IN-1 -> 0; the first valid channel wins.
//     - in_ready = grant & {NUM_IN{load_en}}. No grant when in_valid=0.
//   Transfer (accept)
//     - in_valid[i] & in_ready[i] at posedge: out_data <= channel i, out_sel <= i, out_valid <= 1.
//     - Latency: 1 cycle from acceptance to out_valid.
//   Drain
//     - out_valid & out_ready with no accept in the same cycle: out_valid <= 0.
//     - out_data and out_sel hold their last values after drain.
//   Stall
//     - out_valid & ~out_ready: out_data and out_sel are stable, and in_ready is all zero.
//   Simultaneous drain and accept
//     - The new word replaces the old one in the same edge; out_valid stays 1.
//     - Sustained throughput is 1 word/cycle.
//   Pointer (MODE=1)
//     - On accept from channel i: ptr <= (i==NUM_IN-1) ? 0 : i+1.
//     - ptr is unchanged on cycles with no accept. Wrap is explicit, with no reliance on power-of-two NUM_IN.
//     - MODE=0: ptr is unused and constant 0.
//   Fairness
//     - MODE=1: a continuously valid channel is granted within NUM_IN accepts.
//   Input protocol
//     - An input may drop in_valid without being granted; the arbiter holds no per-input state.
//   Reset mid-operation
//     - A pending output word is discarded and ptr returns to 0.
//     - The first accept after reset follows the reset pointer.
// TESTING
//   1. Reset: hold rst_n=0 with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
//   2. Single channel: MODE=1, in_valid=4'b0100, data2=32'hDEADBEEF, out_ready=1
//      -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hDEADBEEF, out_sel=2.
//   3. Round-robin: MODE=1, in_valid=4'b1111 held, out_ready=1
//      -> out_sel sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
//   4. Fixed priority: MODE=0, in_valid=4'b1010 held, out_ready=1
//      -> out_sel=1 every cycle; channel 3 is never granted.
//   5. Backpressure: load word from ch0, then out_ready=0 for 3 cycles with in_valid=4'b0010
//      -> in_ready=0, out_data/out_sel stable; on out_ready=1, ch1 is accepted in the same cycle.
//   6. Mid-op reset: out_valid=1 with ptr=2, assert rst_n=0 for 1 cycle, then in_valid=4'b1111
//      -> out_valid=0 after reset; first grant goes to channel 0.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: NUM_IN request channels in,
// one registered word out, valid/ready on both sides.
interface rr_arb_mux_if #(
  parameter int SIZE   = 31,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]          in_valid;
  logic [NUM_IN*(SIZE+1)-1:0] in_data;
  logic [NUM_IN-1:0]          in_ready;
  logic                       out_valid;
  logic [SIZE:0]              out_data;
  logic [SEL_W-1:0]           out_sel;
  logic                       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// Registered N:1 arbitrating mux, fixed-priority or round-robin,
// with one output register that sustains a word per cycle.
module rr_arb_mux #(
  parameter int SIZE   = 31,
  parameter int NUM_IN = 4,
  parameter int MODE   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arb_mux_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam int W     = SIZE + 1;

  logic             out_valid_q, out_valid_d;
  logic [SIZE:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic              load_en;
  logic              found;
  logic              accept;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W:0]    cand;
  logic [NUM_IN-1:0] grant;

  // Search upward from the pointer with explicit wrap, so any
  // NUM_IN works; fixed priority just pins the pointer at 0.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(NUM_IN))
        cand = cand - (SEL_W+1)'(NUM_IN);
      if (!found && bus.in_valid[cand[SEL_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[SEL_W-1:0];
      end
    end
    if (found)
      grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    load_en     = ~out_valid_q | bus.out_ready;
    accept      = found & load_en & rst_n;
    out_valid_d = accept | (out_valid_q & ~bus.out_ready);
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_data_d = bus.in_data[gnt_idx*W +: W];
      out_sel_d  = gnt_idx;
      if (MODE == 1) begin
        if (gnt_idx == SEL_W'(NUM_IN-1))
          ptr_d = '0;
        else
          ptr_d = gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = grant & {NUM_IN{load_en & rst_n}};
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule
